// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the led_blink_array LED blinker/PWM block.
package led_blink_pkg;

    // Fixed container widths for one channel's configuration; CNT_W and BURST_W must not exceed these.
    localparam int CFG_CNT_W   = 32;
    localparam int CFG_BURST_W = 16;

    localparam int unsigned DEF_PERIOD_C = 32'd99_999_999;
    localparam int unsigned DEF_DUTY_C   = 32'd50_000_000;

    typedef struct packed {
        logic [CFG_CNT_W-1:0]   period;
        logic [CFG_CNT_W-1:0]   duty;
        logic                   en;
        logic [CFG_BURST_W-1:0] burst;
    } ch_cfg_t;

    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_blink_if.sv
// Write port and LED outputs of led_blink_array, bundled as one interface.
interface led_blink_if
    import led_blink_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 27,
    parameter int BURST_W = 8
);
    localparam int CH_W = clog2_min1(NUM_CH);

    logic               wr_en;
    logic [CH_W-1:0]    wr_ch;
    logic [CNT_W-1:0]   wr_period;
    logic [CNT_W-1:0]   wr_duty;
    logic               wr_chen;
    logic [BURST_W-1:0] wr_burst;
    logic [NUM_CH-1:0]  led;
    logic [NUM_CH-1:0]  done;

    modport master (
        output wr_en, wr_ch, wr_period, wr_duty, wr_chen, wr_burst,
        input  led, done
    );

    modport slave (
        input  wr_en, wr_ch, wr_period, wr_duty, wr_chen, wr_burst,
        output led, done
    );

endinterface

// File: rtl/led_blink_channel.sv
// One LED channel: period counter, shadow/active configuration swapped at the wrap,
// and (with BURST_MODE_EN defined) a finite burst of periods ending in a done pulse.
module led_blink_channel
    import led_blink_pkg::*;
#(
    parameter int          CNT_W      = 27,
    parameter int unsigned DEF_PERIOD = DEF_PERIOD_C,
    parameter int unsigned DEF_DUTY   = DEF_DUTY_C,
    parameter bit          DEF_EN     = 1'b1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    wr,
    input  ch_cfg_t wr_cfg,
    output logic    led,
    output logic    done
);
    localparam ch_cfg_t DEF_CFG = '{
        period: CFG_CNT_W'(CNT_W'(DEF_PERIOD)),
        duty:   CFG_CNT_W'(CNT_W'(DEF_DUTY)),
        en:     DEF_EN,
        burst:  '0
    };

    logic [CNT_W-1:0] cnt;
    ch_cfg_t          act;
    ch_cfg_t          shd;
    ch_cfg_t          nxt;
    logic             wrap;
    logic             xfer;
    logic             unused_act_burst;

    // A write landing on the transfer edge goes straight into the active set.
    always_comb begin
        nxt  = wr ? wr_cfg : shd;
        wrap = act.en && (CFG_CNT_W'(cnt) == act.period);
        xfer = wrap || !act.en;
    end

    assign led              = act.en && (CFG_CNT_W'(cnt) < act.duty);
    assign unused_act_burst = ^act.burst;

`ifdef BURST_MODE_EN
    logic [CFG_BURST_W-1:0] rem;
    logic                   fresh;
`else
    assign done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            act <= DEF_CFG;
            shd <= DEF_CFG;
`ifdef BURST_MODE_EN
            rem   <= '0;
            fresh <= 1'b0;
            done  <= 1'b0;
`endif
        end else begin
            if (wr) shd <= wr_cfg;
            if (xfer) act <= nxt;
            cnt <= (act.en && !wrap) ? cnt + CNT_W'(1) : '0;
`ifdef BURST_MODE_EN
            done <= 1'b0;
            if (wr) fresh <= 1'b1;
            // Only a newly written configuration (re)arms the burst; plain wraps count it down.
            if (xfer && (wr || fresh)) begin
                rem   <= nxt.burst;
                fresh <= 1'b0;
            end else if (wrap && (rem != '0)) begin
                rem <= rem - CFG_BURST_W'(1);
                if (rem == CFG_BURST_W'(1)) begin
                    act.en <= 1'b0;
                    shd.en <= 1'b0;
                    done   <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/led_blink_array.sv
// led_blink_array: NUM_CH independent LED blinker/PWM channels behind one write port.
// Optional finite-burst mode is built when the BURST_MODE_EN macro is defined.
module led_blink_array
    import led_blink_pkg::*;
#(
    parameter int          NUM_CH     = 2,
    parameter int          CNT_W      = 27,
    parameter int          BURST_W    = 8,
    parameter int unsigned DEF_PERIOD = DEF_PERIOD_C,
    parameter int unsigned DEF_DUTY   = DEF_DUTY_C,
    parameter bit          DEF_EN     = 1'b1
) (
    input logic        clk,
    input logic        rst,
    led_blink_if.slave bus
);
    localparam int CH_W = clog2_min1(NUM_CH);

    ch_cfg_t wr_cfg;

    always_comb begin
        wr_cfg        = '0;
        wr_cfg.period = CFG_CNT_W'(bus.wr_period[CNT_W-1:0]);
        wr_cfg.duty   = CFG_CNT_W'(bus.wr_duty[CNT_W-1:0]);
        wr_cfg.en     = bus.wr_chen;
`ifdef BURST_MODE_EN
        wr_cfg.burst  = CFG_BURST_W'(bus.wr_burst[BURST_W-1:0]);
`endif
    end

`ifndef BURST_MODE_EN
    logic unused_wr_burst;
    assign unused_wr_burst = ^bus.wr_burst[BURST_W-1:0];
`endif

    // Channel numbers at or above NUM_CH match no instance, so such writes fall away.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_hit;
        assign wr_hit = bus.wr_en && (bus.wr_ch == CH_W'(i));

        led_blink_channel #(
            .CNT_W     (CNT_W),
            .DEF_PERIOD(DEF_PERIOD),
            .DEF_DUTY  (DEF_DUTY),
            .DEF_EN    (DEF_EN)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .wr    (wr_hit),
            .wr_cfg(wr_cfg),
            .led   (bus.led[i]),
            .done  (bus.done[i])
        );
    end

endmodule
